// File: rtl/serial_addsub_pkg.sv
// serial_addsub shared types.
// FSM encoding and default operand width.
package serial_addsub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// Operand / result handshake bundle for serial_addsub.
// master drives operands and accepts results; slave is the block.
interface serial_addsub_if
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start_valid, op_a, op_b, sub, res_ready,
        input  start_ready, res_valid, result, cout, overflow
    );

    modport slave (
        input  start_valid, op_a, op_b, sub, res_ready,
        output start_ready, res_valid, result, cout, overflow
    );
endinterface

// File: rtl/full_add.sv
// Single-bit full adder cell.
// Used as the bit-slice of serial_addsub.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first.
// One full_add slice plus a carry flop; WIDTH+1 cycles per operation.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    bit_cnt;
    logic             carry;
    logic             c_msb;
    logic             cout_q;
    logic             sum_bit;
    logic             cout_bit;
    logic             last;

    full_add u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .sum (sum_bit),
        .cout(cout_bit)
    );

    assign last = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            bit_cnt <= '0;
            carry   <= 1'b0;
            c_msb   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_sh    <= bus.op_a;
                        b_sh    <= bus.op_b ^ {WIDTH{bus.sub}};
                        carry   <= bus.sub;
                        bit_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= {sum_bit, res_q[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry   <= cout_bit;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (last) begin
                        // park the counter so it never wraps
                        bit_cnt <= '0;
                        c_msb   <= carry;
                        cout_q  <= cout_bit;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign bus.result      = res_q;
    assign bus.cout        = cout_q;
    assign bus.overflow    = c_msb ^ cout_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub.
// Directed vectors, backpressure, mid-run reset, model-checked sweep.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // independent reference: signed overflow from operand/result signs
    function automatic logic [9:0] ref_op(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic s);
        logic [8:0] w;
        logic       v;
        if (s) w = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else   w = {1'b0, a} + {1'b0, b};
        if (s) v = (a[7] != b[7]) && (w[7] != a[7]);
        else   v = (a[7] == b[7]) && (w[7] != a[7]);
        return {v, w[8], w[7:0]};
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input int stall, input bit poke,
                         input logic [7:0] er, input logic ec,
                         input logic ev);
        int n;
        check("start_ready", bus.start_ready, 1);
        bus.op_a        = a;
        bus.op_b        = b;
        bus.sub         = s;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.op_a        = ~a;
        bus.op_b        = ~b;
        bus.sub         = ~s;
        n = 0;
        while (!bus.res_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n + 1, WIDTH + 1);
        check("result", bus.result, er);
        check("cout", bus.cout, ec);
        check("overflow", bus.overflow, ev);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                bus.start_valid = 1'b1;
                bus.op_a        = 8'(i * 37);
                bus.op_b        = 8'(i * 11);
            end
            @(posedge clk); #1;
            bus.start_valid = 1'b0;
            check("hold_valid", bus.res_valid, 1);
            check("hold_result", bus.result, er);
            check("hold_cout", bus.cout, ec);
            if (poke) check("busy_ready", bus.start_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check("back_idle", bus.start_ready, 1);
        check("valid_drop", bus.res_valid, 0);
    endtask

    initial begin
        logic [9:0] m;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        bit         seen;
        total = 0;
        bad   = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.sub         = 1'b0;
        bus.res_ready   = 1'b0;
        #3;
        check("rst_ready", bus.start_ready, 1);
        check("rst_valid", bus.res_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.overflow, 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h35, 8'h4A, 1'b0, 0, 1'b0, 8'h7F, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op(8'h10, 8'h20, 1'b1, 0, 1'b0, 8'hF0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 0, 1'b0, 8'h7F, 1'b1, 1'b1);
        do_op(8'h55, 8'h55, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(8'h00, 8'h01, 1'b1, 0, 1'b0, 8'hFF, 1'b0, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1);

        do_op(8'h12, 8'h34, 1'b0, 5, 1'b1, 8'h46, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("stay_idle", bus.start_ready, 1);

        bus.op_a        = 8'h55;
        bus.op_b        = 8'h0F;
        bus.sub         = 1'b0;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_ready", bus.start_ready, 1);
        check("abort_valid", bus.res_valid, 0);
        check("abort_result", bus.result, 0);
        check("abort_cout", bus.cout, 0);
        check("abort_ovf", bus.overflow, 0);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        do_op(8'h01, 8'h01, 1'b0, 0, 1'b0, 8'h02, 1'b0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            m  = ref_op(ra, rb, rs);
            do_op(ra, rb, rs, int'($urandom_range(0, 3)), 1'b0,
                  m[7:0], m[8], m[9]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial two's-complement adder/subtractor built around the team's existing single-bit `full_add` cell. It accepts two WIDTH-bit operands over a valid/ready handshake and processes one bit per clock, LSB first, through one `full_add` instance and a carry flop. It returns the sum or difference, carry-out and signed overflow over a second valid/ready handshake. This is the multi-cycle, sequential counterpart to the combinational full adder and is intended for area-constrained datapaths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  operands and `sub` are valid this cycle
- start_ready  out  1  block can accept operands; high exactly in IDLE
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- sub  in  1  0 computes A+B; 1 computes A−B (A + ~B + 1)
- res_valid  out  1  result, cout and overflow are valid; high exactly in DONE
- res_ready  in  1  consumer accepts the result
- result  out  WIDTH  sum or difference, modulo 2^WIDTH
- cout  out  1  carry out of the MSB; for subtraction, 1 means no borrow
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - start_ready=1.
  - On start_valid: load a_sh←op_a and b_sh←op_b XOR {WIDTH{sub}}; carry←sub; bit_cnt←0; go to RUN.
- **RUN**, each cycle:
  - full_add inputs are a_sh[0], b_sh[0] and carry.
  - result shifts right with the sum bit entering at result[WIDTH-1].
  - a_sh and b_sh shift right; carry←cout_bit; bit_cnt←bit_cnt+1.
  - When bit_cnt==WIDTH-1: c_msb←carry (carry into MSB); cout←cout_bit; overflow←carry XOR cout_bit; go to DONE.
- **DONE**
  - res_valid=1; result, cout and overflow are held stable.
  - On res_ready go to IDLE.
- start_valid while not in IDLE is ignored; operands are not captured.
- op_a, op_b and sub are sampled only on the accept edge. Later changes have no effect on the operation in flight.
- result, cout and overflow are meaningful only while res_valid=1. In IDLE they keep their last values. During RUN, result contents are undefined.
- bit_cnt width is $clog2(WIDTH) bits. It never wraps inside an operation.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, so start_ready=1 and res_valid=0.
  - result=0, cout=0, overflow=0, carry=0, bit_cnt=0.
- Accept edge is cycle 0. RUN occupies cycles 1..WIDTH. res_valid rises at cycle WIDTH+1.
- Minimum initiation interval is WIDTH+2 cycles (res_ready tied high).
- start_ready and res_valid are decoded from state only. There is no combinational path from any input to any output.
- res_ready is sampled only in DONE. If it is high on the first DONE cycle, the state is IDLE on the next cycle.
- A reset during RUN or DONE aborts the operation immediately. No res_valid is produced for the aborted operands.
- Back-to-back operation: an accept in IDLE on the cycle right after the DONE→IDLE transition is legal.

## Structure
- Package `serial_addsub_pkg` holds:
  - the state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH localparam.
- Exactly one sub-module, `full_add` (ports a, b, cin, sum, cout), instantiated once as the bit-slice.
- All other logic is flat: shift registers, carry flop, counter and FSM.

## Test plan
- WIDTH=8, sub=0, A=0x35, B=0x4A → after 9 cycles result=0x7F, cout=0, overflow=0.
- sub=0, A=0xFF, B=0x01 → result=0x00, cout=1, overflow=0. Then A=0x7F, B=0x01 → result=0x80, cout=0, overflow=1.
- sub=1, A=0x10, B=0x20 → result=0xF0, cout=0 (borrow). Then sub=1, A=0x80, B=0x01 → result=0x7F, cout=1, overflow=1.
- Backpressure case: hold res_ready=0 for 5 DONE cycles.
  - res_valid stays 1 and result stays constant throughout.
  - start_valid pulses during that time are ignored (start_ready=0).
  - Raising res_ready returns the block to IDLE on the next cycle.
- Assert rst_n=0 at RUN cycle 4 and release it.
  - All outputs are 0 and start_ready=1 immediately, and no res_valid follows.
  - The next operation (0x01+0x01) returns 0x02.
- Random regression: 1000 random (A, B, sub) operations with random res_ready stalls, checked against a reference model for result, cout and overflow, plus the latency WIDTH+1.
